// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/func encodings, legal-encoding lists,
// instruction field positions and the fixed-width decoded field bundle.
package decode_pkg;

  localparam int INSTR_W = 32;

  // Field bit positions within the 32-bit instruction word
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

  // Opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int N_LEGAL_OPC = 11;
  localparam int N_LEGAL_FN  = 8;

  localparam logic [N_LEGAL_OPC-1:0][5:0] LEGAL_OPCODES = {
    OPC_RTYPE, OPC_J, OPC_JAL, OPC_BEQ, OPC_BNE, OPC_ADDI,
    OPC_ANDI, OPC_ORI, OPC_LUI, OPC_LW, OPC_SW
  };

  localparam logic [N_LEGAL_FN-1:0][5:0] LEGAL_FUNCS = {
    FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT
  };

  // Register/control fields of one decoded instruction (imm and PC are
  // width-parameterised and are appended by the stage itself)
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] reg1;
    logic [4:0] reg2;
    logic [4:0] dest_reg;
    logic [4:0] shamt;
    logic [5:0] func;
    logic       is_rtype;
  } dec_fields_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL_OPC; i++) begin
      if (op == LEGAL_OPCODES[i]) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic func_legal(input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL_FN; i++) begin
      if (fn == LEGAL_FUNCS[i]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count, synchronous
// flush and asynchronous active-low reset. Head entry is read combinationally.
module decode_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over both ports; never overfill or underflow
  assign do_push = push & ~flush & (count < FULL_CNT);
  assign do_pop  = pop  & ~flush & (count != '0);

  assign rdata = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage_buffered.sv
// Buffered instruction decode stage between fetch and register read.
// Splits each accepted instruction into fields, sign-extends the immediate
// and queues the bundle in a DEPTH-entry FIFO.
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to flag unsupported
// opcodes / R-type function codes; otherwise illegal is tied to 0.
module decode_stage_buffered
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             opcode,
  output logic [4:0]             reg1,
  output logic [4:0]             reg2,
  output logic [4:0]             dest_reg,
  output logic [4:0]             shamt,
  output logic [5:0]             func,
  output logic [XLEN-1:0]        imm,
  output logic                   is_rtype,
  output logic                   illegal,
  output logic [PC_W-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    dec_fields_t     f;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] pc;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic            illegal;
`endif
  } bundle_t;

  bundle_t dec;
  bundle_t head;
  logic    ready_en;
  logic    push;
  logic    pop;

  // Field split of the incoming word; R-type and I-type place registers differently
  always_comb begin
    dec            = '0;
    dec.f.opcode   = instr[OPC_HI:OPC_LO];
    dec.f.is_rtype = (instr[OPC_HI:OPC_LO] == OPC_RTYPE);
    if (dec.f.is_rtype) begin
      dec.f.reg1     = instr[RS_HI:RS_LO];
      dec.f.reg2     = instr[RT_HI:RT_LO];
      dec.f.dest_reg = instr[RD_HI:RD_LO];
    end else begin
      dec.f.reg1     = instr[RT_HI:RT_LO];
      dec.f.reg2     = instr[RS_HI:RS_LO];
      dec.f.dest_reg = instr[RS_HI:RS_LO];
    end
    dec.f.shamt = instr[SH_HI:SH_LO];
    dec.f.func  = instr[FN_HI:FN_LO];
    dec.imm     = {{(XLEN-IMM_W){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
    dec.pc      = in_pc;
`ifdef DECODE_ILLEGAL_CHECK_EN
    dec.illegal = ~opcode_legal(dec.f.opcode) |
                  (dec.f.is_rtype & ~func_legal(dec.f.func));
`endif
  end

  // Holds in_ready low while reset is asserted; opens on the first clock after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign in_ready  = ready_en & (count < DEPTH_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  decode_fifo #(
    .WIDTH ($bits(bundle_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (dec),
    .rdata (head),
    .count (count)
  );

  assign opcode   = head.f.opcode;
  assign reg1     = head.f.reg1;
  assign reg2     = head.f.reg2;
  assign dest_reg = head.f.dest_reg;
  assign shamt    = head.f.shamt;
  assign func     = head.f.func;
  assign is_rtype = head.f.is_rtype;
  assign imm      = head.imm;
  assign out_pc   = head.pc;
`ifdef DECODE_ILLEGAL_CHECK_EN
  assign illegal  = head.illegal;
`else
  assign illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage_buffered.sv
// Directed bench for decode_stage_buffered (XLEN=64, DEPTH=2) with a
// scoreboard queue of expected decoded bundles.
module tb_decode_stage_buffered;

  localparam int XLEN  = 64;
  localparam int PC_W  = 32;
  localparam int DEPTH = 2;
`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       opcode;
  logic [4:0]       reg1;
  logic [4:0]       reg2;
  logic [4:0]       dest_reg;
  logic [4:0]       shamt;
  logic [5:0]       func;
  logic [XLEN-1:0]  imm;
  logic             is_rtype;
  logic             illegal;
  logic [PC_W-1:0]  out_pc;
  logic [1:0]       count;

  decode_stage_buffered #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instr(instr), .in_pc(in_pc), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .reg1(reg1), .reg2(reg2),
    .dest_reg(dest_reg), .shamt(shamt), .func(func), .imm(imm),
    .is_rtype(is_rtype), .illegal(illegal), .out_pc(out_pc), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  r1, r2, rd, sh;
    logic [5:0]  fn;
    logic [63:0] imm;
    logic [31:0] pc;
    logic        rt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   rdy_en   = 1'b0;
  bit   acc;

  function automatic bit op_ok(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
      6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit fn_ok(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    e.op  = w[31:26];
    e.rt  = (w[31:26] == 6'd0);
    e.r1  = e.rt ? w[25:21] : w[20:16];
    e.r2  = e.rt ? w[20:16] : w[25:21];
    e.rd  = e.rt ? w[15:11] : w[25:21];
    e.sh  = w[10:6];
    e.fn  = w[5:0];
    e.imm = 64'($signed(w[15:0]));
    e.pc  = pc;
    e.ill = ILL_EN && (!op_ok(e.op) || (e.rt && !fn_ok(e.fn)));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"},  64'(in_ready),  64'(rdy_en && q.size() < DEPTH));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, ".count"},     64'(count),     64'(q.size()));
    if (q.size() != 0) begin
      chk({tag, ".opcode"}, 64'(opcode),   64'(q[0].op));
      chk({tag, ".reg1"},   64'(reg1),     64'(q[0].r1));
      chk({tag, ".reg2"},   64'(reg2),     64'(q[0].r2));
      chk({tag, ".dest"},   64'(dest_reg), 64'(q[0].rd));
      chk({tag, ".shamt"},  64'(shamt),    64'(q[0].sh));
      chk({tag, ".func"},   64'(func),     64'(q[0].fn));
      chk({tag, ".imm"},    imm,           q[0].imm);
      chk({tag, ".rtype"},  64'(is_rtype), 64'(q[0].rt));
      chk({tag, ".illegal"},64'(illegal),  64'(q[0].ill));
      chk({tag, ".pc"},     64'(out_pc),   64'(q[0].pc));
    end
  endtask

  // Check settled outputs, then advance one clock and update the scoreboard
  task automatic step(input string tag, output bit accepted);
    bit do_push, do_pop;
    #1;
    check_outputs(tag);
    do_push = in_valid && rdy_en && (q.size() < DEPTH) && !flush;
    do_pop  = out_ready && (q.size() != 0) && !flush;
    accepted = do_push;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(model_decode(instr, in_pc));
    end
    rdy_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; in_pc = '0;

    // Reset state
    #2;
    chk("rst.in_ready",  64'(in_ready),  64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.count",     64'(count),     64'd0);
    chk("rst.imm",       imm,            64'd0);
    chk("rst.reg1",      64'(reg1),      64'd0);
    chk("rst.out_pc",    64'(out_pc),    64'd0);
    chk("rst.illegal",   64'(illegal),   64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rel.in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); rdy_en = 1'b1;
    @(negedge clk);
    #1 chk("rel.in_ready_first_edge", 64'(in_ready), 64'd1);

    // R-type add
    instr = 32'h012A4020; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
    step("radd_push", acc);
    in_valid = 1'b0;
    #1;
    chk("radd.reg1",  64'(reg1),     64'd9);
    chk("radd.reg2",  64'(reg2),     64'd10);
    chk("radd.dest",  64'(dest_reg), 64'd8);
    chk("radd.shamt", 64'(shamt),    64'd0);
    chk("radd.func",  64'(func),     64'h20);
    chk("radd.rtype", 64'(is_rtype), 64'd1);
    step("radd_pop", acc);

    // I-type with negative immediate
    instr = 32'h2109FFFC; in_pc = 32'h104; in_valid = 1'b1;
    step("addi_push", acc);
    in_valid = 1'b0;
    #1;
    chk("addi.reg1", 64'(reg1),     64'd9);
    chk("addi.reg2", 64'(reg2),     64'd8);
    chk("addi.dest", 64'(dest_reg), 64'd8);
    chk("addi.imm",  imm,           64'hFFFF_FFFF_FFFF_FFFC);
    chk("addi.rtype",64'(is_rtype), 64'd0);
    step("addi_pop", acc);

    // Fill to full with consumer stalled; third instruction must wait
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h8C430010; in_pc = 32'h200; step("fill_a", acc);
    instr = 32'h00642822; in_pc = 32'h204; step("fill_b", acc);
    instr = 32'h3C017FFF; in_pc = 32'h208; step("fill_c_held", acc);
    chk("full.accept_c", 64'(acc), 64'd0);
    #1;
    chk("full.count",    64'(count),    64'd2);
    chk("full.in_ready", 64'(in_ready), 64'd0);
    chk("full.head_pc",  64'(out_pc),   64'h200);
    step("fill_c_held2", acc);
    out_ready = 1'b1;
    for (int i = 0; i < 8 && in_valid; i++) begin
      step("drain_c", acc);
      if (acc) in_valid = 1'b0;
    end
    chk("drain.c_accepted", 64'(in_valid), 64'd0);
    for (int i = 0; i < 4; i++) step("drain", acc);
    chk("drain.empty", 64'(out_valid), 64'd0);

    // Push and pop on the same edge with one entry queued
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h8D280004; in_pc = 32'h300; step("pp_first", acc);
    instr = 32'hAD280008; in_pc = 32'h304; out_ready = 1'b1; step("pp_both", acc);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("pp.count",   64'(count),  64'd1);
    chk("pp.head_pc", 64'(out_pc), 64'h304);
    out_ready = 1'b1; step("pp_drain", acc);

    // Flush with a full FIFO and a valid input pending
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h01095020; in_pc = 32'h400; step("fl_a", acc);
    instr = 32'h35AB00FF; in_pc = 32'h404; step("fl_b", acc);
    instr = 32'h1000FFFE; in_pc = 32'h408; flush = 1'b1; step("fl_flush", acc);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl.count",     64'(count),     64'd0);
    chk("fl.out_valid", 64'(out_valid), 64'd0);
    chk("fl.in_ready",  64'(in_ready),  64'd1);

    // Unsupported opcode and unsupported R-type function
    in_valid = 1'b1;
    instr = 32'hFC000000; in_pc = 32'h500; step("ill_op", acc);
    instr = 32'h0000003F; in_pc = 32'h504; step("ill_fn", acc);
    in_valid = 1'b0;
    #1 chk("ill.op_flag", 64'(illegal), 64'(ILL_EN));
    out_ready = 1'b1; step("ill_pop1", acc);
    #1 chk("ill.fn_flag", 64'(illegal), 64'(ILL_EN));
    step("ill_pop2", acc);

    // Mixed traffic
    for (int i = 0; i < 60; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      if (!acc || !in_valid) begin end
      instr = $urandom();
      if ($urandom_range(0, 2) == 0) instr[31:26] = 6'h00;
      in_pc = 32'h1000 + 32'(i * 4);
      step("mix", acc);
    end
    flush = 1'b0;

    // Asynchronous reset with two entries queued
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr = 32'h2042FFFF; in_pc = 32'h600 + 32'(i * 4); step("prerst", acc);
    end
    in_valid = 1'b0;
    #1 chk("prerst.count", 64'(count), 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.count",     64'(count),     64'd0);
    chk("arst.imm",       imm,            64'd0);
    chk("arst.in_ready",  64'(in_ready),  64'd0);
    chk("arst.out_pc",    64'(out_pc),    64'd0);
    q.delete(); rdy_en = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); rdy_en = 1'b1;
    @(negedge clk);
    #1 chk("arst.in_ready_after", 64'(in_ready), 64'd1);
    instr = 32'h012A4020; in_pc = 32'h700; in_valid = 1'b1; out_ready = 1'b1;
    step("post_rst_push", acc);
    in_valid = 1'b0;
    step("post_rst_pop", acc);
    step("post_rst_idle", acc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
